// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: EX_MEM bundle layout, MemToReg encodings,
// MEM-stage FSM states and the forwarding-value helper.
package pipe_pkg;

  localparam int EXMEM_W   = 139;
  localparam int WDATA_LSB = 0;
  localparam int ALU_LSB   = 32;
  localparam int WREG_LSB  = 64;
  localparam int MEMRD_BIT = 69;
  localparam int MEMWR_BIT = 70;
  localparam int REGWR_BIT = 71;
  localparam int M2R_LSB   = 72;
  localparam int PC4_LSB   = 74;
  localparam int LUD_LSB   = 106;
  localparam int LUOP_BIT  = 138;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Non-memory result of an instruction: upper-immediate, link address or ALU.
  function automatic logic [31:0] fwd_value(input logic [EXMEM_W-1:0] b);
    logic [31:0] v;
    if (b[LUOP_BIT])
      v = b[LUD_LSB +: 32];
    else if (b[M2R_LSB +: 2] == M2R_PC4)
      v = b[PC4_LSB +: 32];
    else
      v = b[ALU_LSB +: 32];
    return v;
  endfunction

endpackage

// File: rtl/mem_wait_ctrl.sv
// Memory access sequencer: issues the request, counts wait cycles and
// aborts an access that never sees ready within TIMEOUT_CYCLES.
module mem_wait_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic acc,
  input  logic mis,
  input  logic ready,
  output logic req,
  output logic stall,
  output logic abort,
  output logic done
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out;

  // Handshake outputs; reset gates req so it drops even while EX_MEM still holds an access.
  always_comb begin
    timed_out = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    req       = ~reset & ((state_q == ST_WAIT) | (acc & ~mis));
    stall     = req & ~ready & ~timed_out;
    abort     = req & ~ready & timed_out;
    if (state_q == ST_WAIT)
      done = ~reset & ready;
    else
      done = ~reset & ~stall & ~mis;
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req && !ready) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (ready || timed_out) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory access, upstream stall, forwarding taps
// and the MEM_WB register.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [EXMEM_W-1:0]  EX_MEM,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  input  logic                dmem_ready,
  output logic                mem_stall,
  output logic                mem_err,
  output logic [4:0]          EX_MEM_Rd,
  output logic                EX_MEM_RegWrite,
  output logic [31:0]         EX_MEM_RdData,
  output logic [4:0]          MEM_WB_Rd,
  output logic                MEM_WB_RegWrite,
  output logic [31:0]         MEM_WB_RdData
);

  logic        acc, mis;
  logic        abort, done;
  logic [31:0] fwd;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;

  mem_wait_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_ctrl (
    .clk  (clk),
    .reset(reset),
    .acc  (acc),
    .mis  (mis),
    .ready(dmem_ready),
    .req  (dmem_req),
    .stall(mem_stall),
    .abort(abort),
    .done (done)
  );

  // Decode the bundle, drive the memory port and the forwarding taps.
  always_comb begin
    acc             = EX_MEM[MEMRD_BIT] | EX_MEM[MEMWR_BIT];
    mis             = acc & (EX_MEM[ALU_LSB +: 2] != 2'b00);
    fwd             = fwd_value(EX_MEM);
    dmem_we         = EX_MEM[MEMWR_BIT];
    dmem_addr       = EX_MEM[ALU_LSB +: 32];
    dmem_wdata      = EX_MEM[WDATA_LSB +: 32];
    EX_MEM_Rd       = EX_MEM[WREG_LSB +: 5];
    EX_MEM_RegWrite = EX_MEM[REGWR_BIT];
    EX_MEM_RdData   = fwd;
  end

  // MEM_WB loads the result on completion, otherwise a bubble; errors come from
  // a misaligned access (never requested) or a timeout abort.
  always_comb begin
    wb_rd_d   = '0;
    wb_we_d   = 1'b0;
    wb_data_d = '0;
    if (done) begin
      wb_rd_d   = EX_MEM[WREG_LSB +: 5];
      wb_we_d   = EX_MEM[REGWR_BIT];
      wb_data_d = (EX_MEM[M2R_LSB +: 2] == M2R_MEM) ? dmem_rdata : fwd;
    end
    err_d = abort | (mis & ~dmem_req & ~reset);
  end

  // MEM_WB and error-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign MEM_WB_Rd       = wb_rd_q;
  assign MEM_WB_RegWrite = wb_we_q;
  assign MEM_WB_RdData   = wb_data_q;
  assign mem_err         = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instructions checked against a per-instruction behavioural model.
module tb_mem_stage;

  localparam int T = 4;

  typedef struct {
    logic [31:0] wdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rdm;
    logic        wrm;
    logic        regwr;
    logic [1:0]  m2r;
    logic [31:0] pc4;
    logic [31:0] lud;
    logic        luop;
  } instr_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [138:0] ex_mem;
  logic [31:0]  dmem_rdata;
  logic         dmem_ready;
  logic         dmem_req, dmem_we, mem_stall, mem_err;
  logic [31:0]  dmem_addr, dmem_wdata;
  logic [4:0]   ex_mem_rd, mem_wb_rd;
  logic         ex_mem_regwrite, mem_wb_regwrite;
  logic [31:0]  ex_mem_rddata, mem_wb_rddata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .EX_MEM         (ex_mem),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ready     (dmem_ready),
    .mem_stall      (mem_stall),
    .mem_err        (mem_err),
    .EX_MEM_Rd      (ex_mem_rd),
    .EX_MEM_RegWrite(ex_mem_regwrite),
    .EX_MEM_RdData  (ex_mem_rddata),
    .MEM_WB_Rd      (mem_wb_rd),
    .MEM_WB_RegWrite(mem_wb_regwrite),
    .MEM_WB_RdData  (mem_wb_rddata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [138:0] pack(input instr_t i);
    return {i.luop, i.lud, i.pc4, i.m2r, i.regwr, i.wrm, i.rdm, i.rd, i.alu, i.wdata};
  endfunction

  function automatic logic [31:0] model_fwd(input instr_t i);
    if (i.luop) return i.lud;
    if (i.m2r == 2'b10) return i.pc4;
    return i.alu;
  endfunction

  function automatic instr_t blank();
    instr_t i;
    i.wdata = 0; i.alu = 0; i.rd = 0; i.rdm = 0; i.wrm = 0; i.regwr = 0;
    i.m2r = 0; i.pc4 = 0; i.lud = 0; i.luop = 0;
    return i;
  endfunction

  // Run one instruction. Memory answers ready w cycles after the first request
  // (w > T means never). rst_at >= 0 asserts reset in that cycle and stops.
  task automatic run_instr(input instr_t in, input int w, input logic [31:0] rval,
                           input int rst_at, input string name);
    logic        acc, mis, exp_req, rdy, tmo, fin;
    logic [31:0] rd_now;
    int          cycles;
    acc     = in.rdm | in.wrm;
    mis     = acc && (in.alu[1:0] != 2'b00);
    exp_req = acc && !mis;
    cycles  = 0;
    for (int k = 0; k <= T; k++) begin
      @(negedge clk);
      ex_mem     = pack(in);
      rdy        = exp_req ? (k == w) : 1'($urandom % 2);
      rd_now     = (exp_req && k == w) ? rval : $urandom;
      dmem_ready = rdy;
      dmem_rdata = rd_now;
      #1;
      tmo = exp_req && !rdy && (k == T);
      fin = !exp_req || rdy || tmo;
      chk({name, ".req"},   32'(dmem_req),        32'(exp_req));
      chk({name, ".we"},    32'(dmem_we),         32'(in.wrm));
      chk({name, ".addr"},  dmem_addr,            in.alu);
      chk({name, ".wdata"}, dmem_wdata,           in.wdata);
      chk({name, ".stall"}, 32'(mem_stall),       32'(exp_req && !rdy && !tmo));
      chk({name, ".fwdrd"}, 32'(ex_mem_rd),       32'(in.rd));
      chk({name, ".fwdwe"}, 32'(ex_mem_regwrite), 32'(in.regwr));
      chk({name, ".fwdv"},  ex_mem_rddata,        model_fwd(in));
      cycles++;
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        chk({name, ".rst_req"},   32'(dmem_req),        0);
        chk({name, ".rst_stall"}, 32'(mem_stall),       0);
        chk({name, ".rst_wbwe"},  32'(mem_wb_regwrite), 0);
        chk({name, ".rst_wbrd"},  32'(mem_wb_rd),       0);
        chk({name, ".rst_wbd"},   mem_wb_rddata,        0);
        chk({name, ".rst_err"},   32'(mem_err),         0);
        $display("txn %s reset in cycle %0d", name, k);
        return;
      end
      @(posedge clk);
      #1;
      if (fin && !mis && !tmo) begin
        chk({name, ".wbrd"}, 32'(mem_wb_rd),       32'(in.rd));
        chk({name, ".wbwe"}, 32'(mem_wb_regwrite), 32'(in.regwr));
        chk({name, ".wbd"},  mem_wb_rddata,        (in.m2r == 2'b01) ? rd_now : model_fwd(in));
      end else begin
        chk({name, ".wbrd"}, 32'(mem_wb_rd),       0);
        chk({name, ".wbwe"}, 32'(mem_wb_regwrite), 0);
        chk({name, ".wbd"},  mem_wb_rddata,        0);
      end
      chk({name, ".err"}, 32'(mem_err), 32'(mis || tmo));
      if (fin) break;
    end
    $display("txn %s acc=%0d mis=%0d we=%0d w=%0d cycles=%0d", name, acc, mis, in.wrm, w, cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t i;
    reset      = 1'b1;
    ex_mem     = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    #2;
    chk("reset.req",  32'(dmem_req),        0);
    chk("reset.stall",32'(mem_stall),       0);
    chk("reset.err",  32'(mem_err),         0);
    chk("reset.wbwe", 32'(mem_wb_regwrite), 0);
    chk("reset.wbrd", 32'(mem_wb_rd),       0);
    chk("reset.wbd",  mem_wb_rddata,        0);
    @(negedge clk);
    reset = 1'b0;

    i = blank(); i.regwr = 1; i.rd = 8; i.alu = 32'h1234;
    run_instr(i, 0, 0, -1, "alu");

    i = blank(); i.rdm = 1; i.alu = 32'h100; i.m2r = 2'b01; i.rd = 9; i.regwr = 1;
    run_instr(i, 0, 32'hDEADBEEF, -1, "load0");

    i = blank(); i.wrm = 1; i.alu = 32'h40; i.wdata = 32'hA5;
    run_instr(i, 3, 32'h0, -1, "store3");

    i = blank(); i.rdm = 1; i.alu = 32'h200; i.m2r = 2'b01; i.rd = 5; i.regwr = 1;
    run_instr(i, 99, 32'h0, -1, "timeout");

    i = blank(); i.regwr = 1; i.rd = 7; i.m2r = 2'b10; i.pc4 = 32'h1004; i.alu = 32'h55;
    run_instr(i, 0, 0, -1, "after_tmo");

    i = blank(); i.rdm = 1; i.alu = 32'h102; i.m2r = 2'b01; i.rd = 4; i.regwr = 1;
    run_instr(i, 0, 32'h0, -1, "misalign");

    for (int n = 0; n < 60; n++) begin
      i.wdata = $urandom; i.alu = $urandom; i.rd = 5'($urandom);
      i.rdm   = ($urandom % 3) == 0; i.wrm = ($urandom % 3) == 0;
      i.regwr = 1'($urandom); i.m2r = 2'($urandom); i.pc4 = $urandom;
      i.lud   = $urandom; i.luop = ($urandom % 4) == 0;
      if (($urandom % 4) != 0) i.alu[1:0] = 2'b00;
      run_instr(i, $urandom_range(0, T + 1), $urandom, -1, $sformatf("rnd%0d", n));
    end

    i = blank(); i.rdm = 1; i.alu = 32'h300; i.m2r = 2'b01; i.rd = 6; i.regwr = 1;
    run_instr(i, 99, 32'h0, 2, "rst_wait");
    i = blank(); i.luop = 1; i.lud = 32'h56780000; i.regwr = 1; i.rd = 3; i.alu = 32'h99;
    ex_mem = pack(i);
    #2;
    reset = 1'b0;
    run_instr(i, 0, 0, -1, "luop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
